hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 149 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle: source/destination fields of the decoding instruction in,
// forward selects, stall and mul/div status out.
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int TW    = 3,
  parameter int CW    = 32
);
  localparam int SW = $clog2(DEPTH + 1);

  logic [AW-1:0] a1_d;
  logic [AW-1:0] a2_d;
  logic [TW-1:0] tuse_rs_d;
  logic [TW-1:0] tuse_rt_d;
  logic [AW-1:0] a3_d;
  logic          we_d;
  logic [TW-1:0] tnew_d;
  logic          md_start_d;
  logic          md_div_d;
  logic          md_use_d;
  logic          flush;
  logic [SW-1:0] fwd_rs_d;
  logic [SW-1:0] fwd_rt_d;
  logic [SW-1:0] fwd_rs_e;
  logic [SW-1:0] fwd_rt_e;
  logic          stall;
  logic          md_busy;
  logic [CW-1:0] stall_cnt;

  modport master (
    output a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_d, we_d, tnew_d,
           md_start_d, md_div_d, md_use_d, flush,
    input  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall, md_busy, stall_cnt
  );

  modport slave (
    input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_d, we_d, tnew_d,
           md_start_d, md_div_d, md_use_d, flush,
    output fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse pipeline hazard scoreboard: stall and forward selects are combinational from the
// tracked stages; stage state, mul/div busy counter and stall counter update each rising edge.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int DEPTH   = 3,
  parameter int TW      = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CW      = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);
  localparam int SW   = $clog2(DEPTH + 1);
  localparam int MAXL = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MW   = $clog2(MAXL + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t        stg_q [1:DEPTH];
  entry_t        stg_d [1:DEPTH];
  // Source fields only matter in E (for E-stage forwarding), so only stage 1 keeps them.
  logic [AW-1:0] e_a1_q, e_a1_d;
  logic [AW-1:0] e_a2_q, e_a2_d;
  logic [MW-1:0] md_cnt_q, md_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic          rs_hit, rt_hit, rs_e_hit, rt_e_hit;
  logic [SW-1:0] rs_k, rt_k, rs_e_k, rt_e_k;
  logic [TW-1:0] rs_tnew, rt_tnew, rs_e_tnew, rt_e_tnew;
  logic          rs_stall, rt_stall, md_busy, stall;

  // Scan oldest to youngest so the lowest-numbered matching stage is the one left standing.
  always_comb begin
    rs_hit    = 1'b0;
    rt_hit    = 1'b0;
    rs_k      = '0;
    rt_k      = '0;
    rs_tnew   = '0;
    rt_tnew   = '0;
    rs_e_hit  = 1'b0;
    rt_e_hit  = 1'b0;
    rs_e_k    = '0;
    rt_e_k    = '0;
    rs_e_tnew = '0;
    rt_e_tnew = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (stg_q[k].vld && sb.a1_d != '0 && stg_q[k].a3 == sb.a1_d) begin
        rs_hit  = 1'b1;
        rs_k    = SW'(k);
        rs_tnew = stg_q[k].tnew;
      end
      if (stg_q[k].vld && sb.a2_d != '0 && stg_q[k].a3 == sb.a2_d) begin
        rt_hit  = 1'b1;
        rt_k    = SW'(k);
        rt_tnew = stg_q[k].tnew;
      end
    end
    for (int k = DEPTH; k >= 2; k--) begin
      if (stg_q[k].vld && e_a1_q != '0 && stg_q[k].a3 == e_a1_q) begin
        rs_e_hit  = 1'b1;
        rs_e_k    = SW'(k);
        rs_e_tnew = stg_q[k].tnew;
      end
      if (stg_q[k].vld && e_a2_q != '0 && stg_q[k].a3 == e_a2_q) begin
        rt_e_hit  = 1'b1;
        rt_e_k    = SW'(k);
        rt_e_tnew = stg_q[k].tnew;
      end
    end
  end

  assign rs_stall = (sb.tuse_rs_d != TUSE_NONE) && rs_hit && (rs_tnew > sb.tuse_rs_d);
  assign rt_stall = (sb.tuse_rt_d != TUSE_NONE) && rt_hit && (rt_tnew > sb.tuse_rt_d);
  assign md_busy  = (md_cnt_q != '0);
  assign stall    = !reset && (rs_stall || rt_stall || (sb.md_use_d && md_busy));

  assign sb.stall     = stall;
  assign sb.md_busy   = md_busy;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.fwd_rs_d  = (!reset && rs_hit   && rs_tnew   == '0) ? rs_k   : '0;
  assign sb.fwd_rt_d  = (!reset && rt_hit   && rt_tnew   == '0) ? rt_k   : '0;
  assign sb.fwd_rs_e  = (!reset && rs_e_hit && rs_e_tnew == '0) ? rs_e_k : '0;
  assign sb.fwd_rt_e  = (!reset && rt_e_hit && rt_e_tnew == '0) ? rt_e_k : '0;

  always_comb begin
    stg_d[1] = '0;
    e_a1_d   = '0;
    e_a2_d   = '0;
    if (!stall) begin
      stg_d[1].vld  = sb.we_d && (sb.a3_d != '0);
      stg_d[1].a3   = sb.a3_d;
      stg_d[1].tnew = sb.tnew_d;
      e_a1_d        = sb.a1_d;
      e_a2_d        = sb.a2_d;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      stg_d[k] = stg_q[k-1];
      if (stg_q[k-1].tnew != '0) begin
        stg_d[k].tnew = stg_q[k-1].tnew - TW'(1);
      end
    end

    md_cnt_d = md_cnt_q;
    if (sb.md_start_d && !stall) begin
      md_cnt_d = sb.md_div_d ? MW'(DIV_LAT) : MW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MW'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sb.flush) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stg_q[k] <= '0;
      end
      e_a1_q <= '0;
      e_a2_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        stg_q[k] <= stg_d[k];
      end
      e_a1_q <= e_a1_d;
      e_a2_q <= e_a2_d;
    end
  end

  // The mul/div unit runs independently of the pipeline, so only reset stops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector table, hand-written mul/div, flush and reset sequences, then random traffic
// against an integer pipeline model.
module tb_hazard_scoreboard;
  localparam int AW = 5, DEPTH = 3, TW = 3, MUL_LAT = 5, DIV_LAT = 10, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(AW), .DEPTH(DEPTH), .TW(TW), .CW(CW)) sb ();

  hazard_scoreboard #(
    .AW(AW), .DEPTH(DEPTH), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CW(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb)
  );

  typedef struct {
    int a1, a2, trs, trt, a3, we, tnew, ms, md, mu, fl, rst;
    int stall, frs_d, frt_d, frs_e, frt_e, busy, cnt;
  } vec_t;

  int   nvec = 0;
  int   nerr = 0;
  int   vidx = 0;
  int   sc;
  vec_t tbl[$];

  // Integer model of the tracked stages.
  int pv[1:DEPTH], pa3[1:DEPTH], pt[1:DEPTH];
  int e_a1, e_a2, mcnt, scnt;

  function automatic vec_t mk(input int a1, a2, trs, trt, a3, we, tnew, ms, md, mu, fl, rst,
                              input int st, frsd, frtd, frse, frte, busy, cnt);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.trs = trs; v.trt = trt; v.a3 = a3; v.we = we; v.tnew = tnew;
    v.ms = ms; v.md = md; v.mu = mu; v.fl = fl; v.rst = rst;
    v.stall = st; v.frs_d = frsd; v.frt_d = frtd; v.frs_e = frse; v.frt_e = frte;
    v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t idle(input int busy, cnt);
    return mk(0,0,7,7,0,0,0, 0,0,0,0,0, 0,0,0,0,0, busy, cnt);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL vec %0d %s: got %0d expected %0d", vidx, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset         = (v.rst != 0);
    sb.a1_d       = AW'(v.a1);
    sb.a2_d       = AW'(v.a2);
    sb.tuse_rs_d  = TW'(v.trs);
    sb.tuse_rt_d  = TW'(v.trt);
    sb.a3_d       = AW'(v.a3);
    sb.we_d       = (v.we != 0);
    sb.tnew_d     = TW'(v.tnew);
    sb.md_start_d = (v.ms != 0);
    sb.md_div_d   = (v.md != 0);
    sb.md_use_d   = (v.mu != 0);
    sb.flush      = (v.fl != 0);
    #4;
    chk("stall",     int'(sb.stall),     v.stall);
    chk("fwd_rs_d",  int'(sb.fwd_rs_d),  v.frs_d);
    chk("fwd_rt_d",  int'(sb.fwd_rt_d),  v.frt_d);
    chk("fwd_rs_e",  int'(sb.fwd_rs_e),  v.frs_e);
    chk("fwd_rt_e",  int'(sb.fwd_rt_e),  v.frt_e);
    chk("md_busy",   int'(sb.md_busy),   v.busy);
    chk("stall_cnt", int'(sb.stall_cnt), v.cnt);
    vidx++;
    @(posedge clk);
    #1;
  endtask

  // Youngest tracked stage at or after 'lo' that writes 'src', 0 if none.
  function automatic int youngest(input int src, input int lo);
    for (int k = lo; k <= DEPTH; k++)
      if (pv[k] != 0 && pa3[k] == src && src != 0) return k;
    return 0;
  endfunction

  function automatic int ready_sel(input int k);
    return (k != 0 && pt[k] == 0) ? k : 0;
  endfunction

  function automatic int must_wait(input int src, input int tuse);
    int k;
    k = youngest(src, 1);
    return (tuse != 7 && k != 0 && pt[k] > tuse) ? 1 : 0;
  endfunction

  initial begin
    vec_t v;
    int   st;

    reset = 1'b1;
    sb.a1_d = '0; sb.a2_d = '0; sb.tuse_rs_d = '1; sb.tuse_rt_d = '1;
    sb.a3_d = '0; sb.we_d = 1'b0; sb.tnew_d = '0;
    sb.md_start_d = 1'b0; sb.md_div_d = 1'b0; sb.md_use_d = 1'b0; sb.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            a1 a2 trs trt a3 we tn  ms md mu fl rst  st rsd rtd rse rte busy cnt
    tbl.push_back(mk(0,0,7,7,0,0,0, 0,0,0,0,1, 0,0,0,0,0, 0,0));
    // load-use: lw $5 (tnew 2), consumer needs it in D
    tbl.push_back(mk(0,0,7,7,5,1,2, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(5,0,0,7,0,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(5,0,0,7,0,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,1));
    tbl.push_back(mk(5,0,0,7,0,0,0, 0,0,0,0,0, 0,3,0,0,0, 0,2));
    repeat (3) tbl.push_back(idle(0, 2));
    // ALU to branch in D
    tbl.push_back(mk(0,0,7,7,3,1,1, 0,0,0,0,0, 0,0,0,0,0, 0,2));
    tbl.push_back(mk(0,3,7,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,2));
    tbl.push_back(mk(0,3,7,0,0,0,0, 0,0,0,0,0, 0,0,2,0,0, 0,3));
    tbl.push_back(mk(0,0,7,7,0,0,0, 0,0,0,0,0, 0,0,0,0,3, 0,3));
    repeat (2) tbl.push_back(idle(0, 3));
    // ALU to consumer needing it one cycle later: forwarded in E
    tbl.push_back(mk(0,0,7,7,3,1,1, 0,0,0,0,0, 0,0,0,0,0, 0,3));
    tbl.push_back(mk(0,3,7,1,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,3));
    tbl.push_back(mk(0,0,7,7,0,0,0, 0,0,0,0,0, 0,0,0,0,2, 0,3));
    repeat (2) tbl.push_back(idle(0, 3));
    // youngest writer wins; writes to $0 never tracked
    tbl.push_back(mk(0,0,7,7,4,1,0, 0,0,0,0,0, 0,0,0,0,0, 0,3));
    tbl.push_back(mk(0,0,7,7,4,1,0, 0,0,0,0,0, 0,0,0,0,0, 0,3));
    tbl.push_back(mk(4,0,0,7,0,0,0, 0,0,0,0,0, 0,1,0,0,0, 0,3));
    tbl.push_back(mk(0,0,7,7,0,1,2, 0,0,0,0,0, 0,0,0,2,0, 0,3));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,3));
    repeat (2) tbl.push_back(idle(0, 3));
    // flush in the middle of a load-use stall
    tbl.push_back(mk(0,0,7,7,6,1,2, 0,0,0,0,0, 0,0,0,0,0, 0,3));
    tbl.push_back(mk(6,0,0,7,0,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,3));
    tbl.push_back(mk(6,0,0,7,0,0,0, 0,0,0,1,0, 1,0,0,0,0, 0,4));
    tbl.push_back(mk(6,0,0,7,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,5));
    tbl.push_back(idle(0, 5));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // divide then mfhi, then multiply then mfhi; stall counter saturates along the way
    sc = 5;
    for (int op = 0; op < 2; op++) begin
      int lat;
      lat = (op == 0) ? DIV_LAT : MUL_LAT;
      apply(mk(0,0,7,7,0,0,0, 1,(op == 0) ? 1 : 0,0,0,0, 0,0,0,0,0, 0,sc));
      for (int i = 0; i < lat; i++) begin
        apply(mk(0,0,7,7,0,0,0, 0,0,1,0,0, 1,0,0,0,0, 1,sc));
        sc = (sc == CMAX) ? CMAX : sc + 1;
      end
      apply(mk(0,0,7,7,0,0,0, 0,0,1,0,0, 0,0,0,0,0, 0,sc));
    end

    // flush during a load-use stall leaves the running divide alone
    apply(mk(0,0,7,7,0,0,0, 1,1,0,0,0, 0,0,0,0,0, 0,sc));
    apply(mk(0,0,7,7,7,1,2, 0,0,0,0,0, 0,0,0,0,0, 1,sc));
    apply(mk(7,0,0,7,0,0,0, 0,0,0,1,0, 1,0,0,0,0, 1,sc));
    sc = (sc == CMAX) ? CMAX : sc + 1;
    apply(mk(7,0,0,7,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 1,sc));
    for (int i = 0; i < 7; i++) apply(idle(1, sc));
    apply(idle(0, sc));

    // reset with a divide running and a load pending
    apply(mk(0,0,7,7,0,0,0, 1,1,0,0,0, 0,0,0,0,0, 0,sc));
    apply(mk(0,0,7,7,8,1,2, 0,0,0,0,0, 0,0,0,0,0, 1,sc));
    apply(mk(8,0,0,7,0,0,0, 0,0,1,0,1, 0,0,0,0,0, 1,sc));
    apply(mk(8,0,0,7,0,0,0, 0,0,1,0,0, 0,0,0,0,0, 0,0));

    // random traffic against the model; the first cycle resets both sides
    for (int k = 1; k <= DEPTH; k++) begin pv[k] = 0; pa3[k] = 0; pt[k] = 0; end
    e_a1 = 0; e_a2 = 0; mcnt = 0; scnt = 0;
    for (int n = 0; n < 3000; n++) begin
      v.a1   = $urandom_range(0, 3);
      v.a2   = $urandom_range(0, 3);
      v.trs  = $urandom_range(0, 7);
      v.trt  = $urandom_range(0, 7);
      v.a3   = $urandom_range(0, 3);
      v.we   = $urandom_range(0, 1);
      v.tnew = $urandom_range(0, 3);
      v.ms   = ($urandom_range(0, 19) == 0) ? 1 : 0;
      v.md   = $urandom_range(0, 1);
      v.mu   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      v.fl   = ($urandom_range(0, 29) == 0) ? 1 : 0;
      v.rst  = (n == 0 || $urandom_range(0, 199) == 0) ? 1 : 0;

      st = (v.rst == 0 && (must_wait(v.a1, v.trs) != 0 || must_wait(v.a2, v.trt) != 0 ||
                          (v.mu != 0 && mcnt != 0))) ? 1 : 0;
      v.stall = st;
      v.frs_d = (v.rst != 0) ? 0 : ready_sel(youngest(v.a1, 1));
      v.frt_d = (v.rst != 0) ? 0 : ready_sel(youngest(v.a2, 1));
      v.frs_e = (v.rst != 0) ? 0 : ready_sel(youngest(e_a1, 2));
      v.frt_e = (v.rst != 0) ? 0 : ready_sel(youngest(e_a2, 2));
      v.busy  = (mcnt != 0) ? 1 : 0;
      v.cnt   = scnt;
      apply(v);

      if (v.rst != 0 || v.fl != 0) begin
        for (int k = 1; k <= DEPTH; k++) begin pv[k] = 0; pa3[k] = 0; pt[k] = 0; end
        e_a1 = 0; e_a2 = 0;
      end else begin
        for (int k = DEPTH; k >= 2; k--) begin
          pv[k]  = pv[k-1];
          pa3[k] = pa3[k-1];
          pt[k]  = (pt[k-1] > 0) ? pt[k-1] - 1 : 0;
        end
        pv[1]  = (st == 0 && v.we != 0 && v.a3 != 0) ? 1 : 0;
        pa3[1] = (st == 0) ? v.a3 : 0;
        pt[1]  = (st == 0) ? v.tnew : 0;
        e_a1   = (st == 0) ? v.a1 : 0;
        e_a2   = (st == 0) ? v.a2 : 0;
      end
      if (v.rst != 0) begin
        mcnt = 0;
        scnt = 0;
      end else begin
        if (st != 0 && scnt < CMAX) scnt++;
        if (v.ms != 0 && st == 0) mcnt = (v.md != 0) ? DIV_LAT : MUL_LAT;
        else if (mcnt > 0) mcnt--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
